// File: rtl/vec_accum.sv
// Leaky vector accumulator. It consumes a time-multiplexed element stream and keeps one
// saturating 18-bit state per element. Frames start a fixed latency after the start strobe.
module vec_accum #(
    parameter int aw  = 4,
    parameter int lat = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [aw:0]        n,
    input  logic               load,
    input  logic [3:0]         leak,
    input  logic signed [17:0] din,
    output logic signed [17:0] dout,
    output logic               dout_valid,
    output logic [aw-1:0]      dout_idx,
    output logic               frame_done,
    output logic               sat,
    input  logic               sat_clr
);
    localparam int depth = 1 << aw;
    localparam logic [aw:0] n_full = (aw + 1)'(depth);
    localparam logic signed [19:0] pos_lim = 20'sd131071;
    localparam logic signed [19:0] neg_lim = -20'sd131071;

    logic [aw:0] n_cap;
    assign n_cap = (n == '0 || n > n_full) ? n_full : n;

    // Each start travels with its own frame parameters, so overlapping starts stay independent.
    logic        dl_vld_reg  [lat];
    logic [aw:0] dl_n_reg    [lat];
    logic        dl_load_reg [lat];
    logic [3:0]  dl_leak_reg [lat];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < lat; i++) begin
                dl_vld_reg[i]  <= 1'b0;
                dl_n_reg[i]    <= '0;
                dl_load_reg[i] <= 1'b0;
                dl_leak_reg[i] <= '0;
            end
        end else begin
            dl_vld_reg[0]  <= start;
            dl_n_reg[0]    <= n_cap;
            dl_load_reg[0] <= load;
            dl_leak_reg[0] <= leak;
            for (int i = 1; i < lat; i++) begin
                dl_vld_reg[i]  <= dl_vld_reg[i-1];
                dl_n_reg[i]    <= dl_n_reg[i-1];
                dl_load_reg[i] <= dl_load_reg[i-1];
                dl_leak_reg[i] <= dl_leak_reg[i-1];
            end
        end
    end

    logic              frame_begin;
    logic              active_reg;
    logic [aw-1:0]     idx_reg;
    logic [aw:0]       n_reg;
    logic              load_reg;
    logic [3:0]        leak_reg;
    logic              cur_active;
    logic [aw-1:0]     cur_idx;
    logic [aw:0]       cur_n;
    logic              cur_load;
    logic [3:0]        cur_leak;

    assign frame_begin = dl_vld_reg[lat-1];

    // A frame-begin takes over in the same cycle that element 0 is on din, aborting any frame in flight.
    always_comb begin
        cur_active = frame_begin | active_reg;
        cur_idx    = idx_reg;
        cur_n      = n_reg;
        cur_load   = load_reg;
        cur_leak   = leak_reg;
        if (frame_begin) begin
            cur_idx  = '0;
            cur_n    = dl_n_reg[lat-1];
            cur_load = dl_load_reg[lat-1];
            cur_leak = dl_leak_reg[lat-1];
        end
    end

    logic [depth*18-1:0] state_flat;
    logic signed [17:0]  rd;
    logic signed [19:0]  rd_ext;
    logic signed [19:0]  din_ext;
    logic signed [19:0]  leak_amt;
    logic signed [19:0]  base;
    logic signed [19:0]  sum;
    logic signed [17:0]  wr_val;
    logic                clip;
    logic                last;

    assign rd      = state_flat[int'(cur_idx)*18 +: 18];
    assign rd_ext  = {{2{rd[17]}}, rd};
    assign din_ext = {{2{din[17]}}, din};
    assign last    = ({1'b0, cur_idx} == cur_n - 1'b1);

    always_comb begin
        leak_amt = '0;
        if (cur_leak != 4'd0) leak_amt = rd_ext >>> cur_leak;
        base = '0;
        if (!cur_load) base = rd_ext - leak_amt;
        sum    = base + din_ext;
        clip   = 1'b0;
        wr_val = sum[17:0];
        // Symmetric clamp: the most negative code is never produced.
        if (sum > pos_lim) begin
            wr_val = pos_lim[17:0];
            clip   = 1'b1;
        end else if (sum < neg_lim) begin
            wr_val = neg_lim[17:0];
            clip   = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < depth; gi++) begin : g_elem
            logic signed [17:0] elem_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    elem_reg <= '0;
                end else if (cur_active && cur_idx == aw'(gi)) begin
                    elem_reg <= wr_val;
                end
            end
            assign state_flat[gi*18 +: 18] = elem_reg;
        end
    endgenerate

    logic signed [17:0] dout_reg;
    logic [aw-1:0]      dout_idx_reg;
    logic               dout_valid_reg;
    logic               frame_done_reg;
    logic               sat_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg     <= 1'b0;
            idx_reg        <= '0;
            n_reg          <= '0;
            load_reg       <= 1'b0;
            leak_reg       <= '0;
            dout_reg       <= '0;
            dout_idx_reg   <= '0;
            dout_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            sat_reg        <= 1'b0;
        end else begin
            active_reg     <= cur_active && !last;
            n_reg          <= cur_n;
            load_reg       <= cur_load;
            leak_reg       <= cur_leak;
            dout_valid_reg <= cur_active;
            frame_done_reg <= cur_active && last;
            if (cur_active) begin
                idx_reg      <= cur_idx + 1'b1;
                dout_reg     <= wr_val;
                dout_idx_reg <= cur_idx;
            end
            if (cur_active && clip) sat_reg <= 1'b1;
            else if (sat_clr)       sat_reg <= 1'b0;
        end
    end

    assign dout       = dout_reg;
    assign dout_idx   = dout_idx_reg;
    assign dout_valid = dout_valid_reg;
    assign frame_done = frame_done_reg;
    assign sat        = sat_reg;
endmodule

// File: tb/tb_vec_accum.sv
// Directed and randomized checks of vec_accum against a per-frame arithmetic model
// that works from pending-frame lists and integer math.
module tb_vec_accum;
    localparam int AW    = 4;
    localparam int LAT   = 6;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [AW:0]        n = '0;
    logic               load = 1'b0;
    logic [3:0]         leak = '0;
    logic signed [17:0] din = '0;
    logic               sat_clr = 1'b0;
    logic signed [17:0] dout;
    logic               dout_valid;
    logic [AW-1:0]      dout_idx;
    logic               frame_done;
    logic               sat;

    vec_accum #(.aw(AW), .lat(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n), .load(load), .leak(leak),
        .din(din), .dout(dout), .dout_valid(dout_valid), .dout_idx(dout_idx),
        .frame_done(frame_done), .sat(sat), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    typedef struct {int due; int nn; bit ld; int lk;} pend_t;
    pend_t pend[$];
    int    m_state[DEPTH];
    int    m_dout, m_idx_out, m_idx, m_n, m_lk, cyc;
    bit    m_valid, m_fd, m_sat, m_active, m_ld;
    int    checks = 0, errors = 0, fd_seen = 0;
    int    fq[$];

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) m_state[k] = 0;
        pend.delete();
        m_dout = 0; m_idx_out = 0; m_valid = 0; m_fd = 0; m_sat = 0; m_active = 0; m_idx = 0;
    endtask

    // Apply one clock's worth of the accumulator rules to the inputs currently driven.
    task automatic model_step();
        int s, v;
        bit clip;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            pend_t p = pend.pop_front();
            m_n = p.nn; m_ld = p.ld; m_lk = p.lk; m_idx = 0; m_active = 1;
        end
        if (start) begin
            int nn = int'(n);
            if (nn == 0 || nn > DEPTH) nn = DEPTH;
            pend.push_back('{cyc + LAT, nn, load, int'(leak)});
        end
        clip = 0;
        if (m_active) begin
            int cur = m_state[m_idx];
            if (m_ld) s = 0;
            else if (m_lk == 0) s = cur;
            else s = cur - (cur >>> m_lk);
            s = s + int'(din);
            v = s;
            if (s > 131071) v = 131071;
            if (s < -131071) v = -131071;
            clip = (v != s);
            m_state[m_idx] = v;
            m_dout = v; m_idx_out = m_idx; m_valid = 1;
            m_fd = (m_idx == m_n - 1);
            if (m_fd) m_active = 0;
            m_idx++;
        end else begin
            m_valid = 0; m_fd = 0;
        end
        if (clip) m_sat = 1;
        else if (sat_clr) m_sat = 0;
        cyc++;
    endtask

    task automatic check_outputs();
        chk("dout", dout, m_dout);
        chk("dout_valid", dout_valid, m_valid);
        chk("dout_idx", dout_idx, m_idx_out);
        chk("frame_done", frame_done, m_fd);
        chk("sat", sat, m_sat);
        if (frame_done === 1'b1) fd_seen++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drv(bit st, int nn, bit ld, int lk, int d, bit sclr);
        start = st; n = (AW + 1)'(nn); load = ld; leak = 4'(lk); din = 18'(d); sat_clr = sclr;
        tick();
    endtask

    function automatic int rdin();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 262143)) - 131072;
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    task automatic idle(bit sclr);
        drv(1'b0, int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), rdin(), sclr);
    endtask

    // Start a frame, wait out the latency with junk inputs, then stream fq as the elements.
    task automatic frame(int nn, bit ld, int lk, bit sclr);
        drv(1'b1, nn, ld, lk, rdin(), sclr);
        repeat (LAT - 1) idle(sclr);
        foreach (fq[k]) drv(1'b0, int'($urandom_range(0, 31)), 1'b0, 0, fq[k], sclr);
    endtask

    task automatic set1(int a);
        fq.delete(); fq.push_back(a);
    endtask

    task automatic set4(int a, int b, int c, int d);
        fq.delete(); fq.push_back(a); fq.push_back(b); fq.push_back(c); fq.push_back(d);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        start = 1'b0; sat_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        int nn, eff;
        model_reset();
        cyc = 0;
        @(posedge clk);
        #1 check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic frame, accumulate, then overwrite.
        set4(10, 20, 30, 40);
        frame(4, 1'b0, 0, 1'b0);
        chk("basic_last_dout", dout, 40);
        chk("basic_frame_done", frame_done, 1);
        idle(1'b0);
        chk("basic_done_gone", frame_done, 0);
        frame(4, 1'b0, 0, 1'b0);
        chk("accum_last_dout", dout, 80);
        set4(5, 5, 5, 5);
        frame(4, 1'b1, 0, 1'b0);
        chk("load_last_dout", dout, 5);

        // Saturation positive, negative full scale, and clear priority.
        set1(131000);
        frame(1, 1'b1, 0, 1'b0);
        set1(100);
        frame(1, 1'b0, 0, 1'b0);
        chk("sat_pos_dout", dout, 131071);
        idle(1'b0);
        chk("sat_set", sat, 1);
        idle(1'b1);
        chk("sat_cleared", sat, 0);
        set1(-131072);
        frame(1, 1'b1, 0, 1'b1);
        chk("sat_neg_dout", dout, -131071);
        chk("sat_set_beats_clr", sat, 1);
        idle(1'b1);

        // Leak.
        set1(1024);
        frame(1, 1'b1, 0, 1'b0);
        set1(0);
        frame(1, 1'b0, 2, 1'b0);
        chk("leak_dout", dout, 768);

        // Restart two cycles after a start: only the second frame completes.
        fd_seen = 0;
        drv(1'b1, 8, 1'b1, 0, rdin(), 1'b0);
        drv(1'b0, 0, 1'b0, 0, rdin(), 1'b0);
        drv(1'b1, 4, 1'b0, 1, rdin(), 1'b0);
        repeat (16) idle(1'b0);
        chk("restart_frame_done_count", fd_seen, 1);

        // Randomized frames including n = 0 and n above the vector size.
        for (int i = 0; i < 12; i++) begin
            nn  = int'($urandom_range(0, 20));
            eff = (nn == 0 || nn > DEPTH) ? DEPTH : nn;
            fq.delete();
            for (int k = 0; k < eff; k++) fq.push_back(rdin());
            frame(nn, bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) idle(bit'($urandom_range(0, 1)));
        end

        // Reset mid-frame: outputs clear, no further writes, state reads back as zero.
        drv(1'b1, 16, 1'b0, 0, rdin(), 1'b0);
        repeat (LAT + 3) idle(1'b0);
        do_reset();
        fd_seen = 0;
        repeat (12) idle(1'b0);
        chk("post_reset_quiet", fd_seen, 0);
        set4(1, 2, 3, 4);
        frame(4, 1'b0, 0, 1'b0);
        chk("post_reset_state_zero", dout, 4);
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
